spike_counter: RTL and testbench
================================

Name: spike_counter

Overview:
- Downstream consumer of the motoneuron pool's spike output.
- Detects rising edges of the spike line and counts them over a programmable window of clk cycles.
- Latches each window's count into an output register with a valid/ack handshake for the host readout path.
- Tracks the last inter-spike interval (ISI) and a saturating running total, for rate/force stages and debug.

Parameters:
- CNT_W, 16, width of per-window count and running total (both saturate at 2^CNT_W-1).
- ISI_W, 32, width of ISI cycle counter (saturates at 2^ISI_W-1).

Ports:
- clk  input  1  block clock; all logic on rising edge.
- reset_sim  input  1  synchronous, active-high reset.
- enable  input  1  0 = hold idle; all counters are cleared every cycle while low.
- window_len  input  32  window length in clk cycles; 0 = idle.
- spike  input  1  spike level, synchronous to clk.
- count_ack  input  1  host acknowledges the current count_out.
- count_out  output  CNT_W  spikes in the last closed window.
- count_valid  output  1  count_out holds unacknowledged data.
- overrun  output  1  sticky; a window closed while count_valid=1 and count_ack=0.
- total_count  output  CNT_W  saturating spike count since reset or enable rise.
- last_isi  output  ISI_W  clk cycles between the last two spike edges.
- window_tick  output  1  one-cycle pulse on the cycle after a window closes.

Behaviour:
- Reset (reset_sim=1 at a clk edge): all outputs and internal registers go to 0, including spike_d, the cycle counter, win_cnt, isi_cnt and the first_seen flag. Reset mid-window discards partial counts.
- Edge detect:
  - spike_d <= spike.
  - edge = spike & ~spike_d.
  - A spike held high for N cycles counts once.
- States:
  - IDLE: entered on reset, when enable=0, or when window_len=0. Cycle counter, win_cnt, isi_cnt, first_seen and total_count are held at 0. Outputs count_out, count_valid, overrun and last_isi keep their values, except on reset.
  - IDLE -> COUNT: when enable=1 and window_len!=0. The first COUNT cycle is cycle 0 of a window.
  - COUNT -> IDLE: when enable drops or window_len becomes 0. The partial window is discarded and nothing is latched.
- COUNT cycle rules:
  - Each cycle: win_cnt += edge (saturating); total_count += edge (saturating); the cycle counter increments.
  - Window close occurs when cycle counter >= window_len-1. The comparison is live, so shrinking window_len mid-window closes on the next cycle that meets it.
  - On close:
    - count_out <= win_cnt + edge (saturating), so an edge on the closing cycle belongs to the closing window.
    - win_cnt <= 0; cycle counter <= 0.
    - window_tick=1 on the next cycle.
    - count_valid <= 1.
  - Latency: count_out and count_valid update 1 cycle after the closing cycle.
- Handshake:
  - count_ack=1 while count_valid=1 and no close occurs: count_valid <= 0 next cycle.
  - count_ack while count_valid=0 is ignored.
  - Close while count_valid=1 and count_ack=0: count_out is overwritten, count_valid stays 1, overrun <= 1.
  - Close and count_ack in the same cycle: new data is loaded, count_valid stays 1, no overrun.
  - overrun clears only on reset_sim.
- ISI:
  - isi_cnt increments each COUNT cycle (saturating) and resets to 1 on an edge.
  - On an edge with first_seen=1: last_isi <= isi_cnt. On the first edge: first_seen <= 1 and last_isi is unchanged.
  - Example: edges on COUNT cycles 3 and 10 give last_isi=7.
- Arithmetic: all counts are unsigned. Saturation holds at the max value and never wraps.

Decomposition:
- Shared package constants: default CNT_W/ISI_W, the state encoding (IDLE=0, COUNT=1), and the saturating-increment function.
- One natural sub-module: spike_edge_detect (spike, spike_d register -> edge). Everything else stays in spike_counter.

Test Plan:
- Reset/idle: reset_sim high 3 cycles, then enable=1 with window_len=0 for 20 cycles -> all outputs 0, window_tick never pulses.
- Basic window: window_len=10, spike pulses (1 cycle each) on cycles 2, 5, 9 -> count_out=3, count_valid=1 on cycle 10, window_tick on cycle 10; ack -> count_valid=0 next cycle.
- Held level: spike high on cycles 0-7 of a 10-cycle window -> count_out=1; total_count=1.
- Overrun: window_len=4, spikes every window, no ack for 3 windows -> overrun=1 after 2nd close, count_out = latest window; ack coinciding with a close -> count_valid stays 1, overrun unchanged.
- ISI and saturation: CNT_W=4, spike toggling every 2 cycles with window_len=100 -> count_out=15, total_count=15; last_isi=2.
- Mid-operation changes: window_len 100 -> 5 at cycle 20 -> close on cycle 21; enable low mid-window -> no latch, total_count=0, count_out retains the previous value.

Source files
------------

// File: rtl/spike_counter_pkg.sv
// Shared constants, state encoding and saturating-increment helper
// for the spike counter readout block.
package spike_counter_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int ISI_W_DEF = 32;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    // Adds inc to val but never moves past max_val; callers narrow the result.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] val,
        input logic [31:0] max_val,
        input logic        inc
    );
        if (inc && (val != max_val)) begin
            return val + 32'd1;
        end
        return val;
    endfunction

endpackage

// File: rtl/spike_counter_edge_detect.sv
// Rising-edge detector on the synchronous spike level; a held-high
// spike produces a single edge.
module spike_edge_detect (
    input  logic clk,
    input  logic reset_sim,
    input  logic spike,
    output logic spike_edge
);

    logic spike_d_reg;

    always_ff @(posedge clk) begin
        if (reset_sim) begin
            spike_d_reg <= 1'b0;
        end else begin
            spike_d_reg <= spike;
        end
    end

    assign spike_edge = spike & ~spike_d_reg;

endmodule

// File: rtl/spike_counter.sv
// Windowed spike counter with valid/ack readout, sticky overrun,
// saturating running total and last inter-spike interval.
module spike_counter
    import spike_counter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ISI_W = ISI_W_DEF
) (
    input  logic             clk,
    input  logic             reset_sim,
    input  logic             enable,
    input  logic [31:0]      window_len,
    input  logic             spike,
    input  logic             count_ack,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overrun,
    output logic [CNT_W-1:0] total_count,
    output logic [ISI_W-1:0] last_isi,
    output logic             window_tick
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] ISI_MAX = 32'((64'd1 << ISI_W) - 64'd1);

    logic [0:0]       state_reg;
    logic [31:0]      cyc_reg;
    logic [CNT_W-1:0] win_cnt_reg;
    logic [CNT_W-1:0] total_reg;
    logic [ISI_W-1:0] isi_cnt_reg;
    logic             first_seen_reg;
    logic [CNT_W-1:0] count_out_reg;
    logic             count_valid_reg;
    logic             overrun_reg;
    logic [ISI_W-1:0] last_isi_reg;
    logic             tick_reg;

    logic             spike_edge;
    logic             active;
    logic             counting;
    logic             win_close;
    logic [CNT_W-1:0] win_sum;

    spike_edge_detect u_edge (
        .clk        (clk),
        .reset_sim  (reset_sim),
        .spike      (spike),
        .spike_edge (spike_edge)
    );

    assign active    = enable && (window_len != 32'd0);
    // Counting needs both the registered state and a still-valid request,
    // so dropping enable or zeroing window_len discards the window at once.
    assign counting  = (state_reg == ST_COUNT) && active;
    assign win_close = counting && (cyc_reg >= window_len - 32'd1);
    assign win_sum   = CNT_W'(sat_inc(32'(win_cnt_reg), CNT_MAX, spike_edge));

    always_ff @(posedge clk) begin
        if (reset_sim) begin
            state_reg       <= ST_IDLE;
            cyc_reg         <= '0;
            win_cnt_reg     <= '0;
            total_reg       <= '0;
            isi_cnt_reg     <= '0;
            first_seen_reg  <= 1'b0;
            count_out_reg   <= '0;
            count_valid_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            last_isi_reg    <= '0;
            tick_reg        <= 1'b0;
        end else begin
            state_reg <= active ? ST_COUNT : ST_IDLE;
            tick_reg  <= win_close;

            if (!counting) begin
                cyc_reg        <= '0;
                win_cnt_reg    <= '0;
                total_reg      <= '0;
                isi_cnt_reg    <= '0;
                first_seen_reg <= 1'b0;
            end else begin
                total_reg <= CNT_W'(sat_inc(32'(total_reg), CNT_MAX, spike_edge));
                if (win_close) begin
                    cyc_reg     <= '0;
                    win_cnt_reg <= '0;
                end else begin
                    cyc_reg     <= cyc_reg + 32'd1;
                    win_cnt_reg <= win_sum;
                end
                if (spike_edge) begin
                    isi_cnt_reg    <= ISI_W'(1);
                    first_seen_reg <= 1'b1;
                    if (first_seen_reg) begin
                        last_isi_reg <= isi_cnt_reg;
                    end
                end else begin
                    isi_cnt_reg <= ISI_W'(sat_inc(32'(isi_cnt_reg), ISI_MAX, 1'b1));
                end
            end

            // A close always wins over ack; overrun only when the host missed data.
            if (win_close) begin
                count_out_reg   <= win_sum;
                count_valid_reg <= 1'b1;
                if (count_valid_reg && !count_ack) begin
                    overrun_reg <= 1'b1;
                end
            end else if (count_valid_reg && count_ack) begin
                count_valid_reg <= 1'b0;
            end
        end
    end

    assign count_out   = count_out_reg;
    assign count_valid = count_valid_reg;
    assign overrun     = overrun_reg;
    assign total_count = total_reg;
    assign last_isi    = last_isi_reg;
    assign window_tick = tick_reg;

endmodule

// File: tb/tb_spike_counter.sv
// Directed bench for spike_counter: default-width and 4-bit-count instances
// share stimulus; expected values are hand-computed per scenario.
module tb_spike_counter;

    logic        clk = 1'b0;
    logic        reset_sim;
    logic        enable;
    logic [31:0] window_len;
    logic        spike;
    logic        count_ack;

    logic [15:0] count_out;
    logic        count_valid;
    logic        overrun;
    logic [15:0] total_count;
    logic [31:0] last_isi;
    logic        window_tick;

    logic [3:0]  c4_count_out;
    logic        c4_count_valid;
    logic        c4_overrun;
    logic [3:0]  c4_total_count;
    logic [31:0] c4_last_isi;
    logic        c4_window_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spike_counter dut (
        .clk         (clk),
        .reset_sim   (reset_sim),
        .enable      (enable),
        .window_len  (window_len),
        .spike       (spike),
        .count_ack   (count_ack),
        .count_out   (count_out),
        .count_valid (count_valid),
        .overrun     (overrun),
        .total_count (total_count),
        .last_isi    (last_isi),
        .window_tick (window_tick)
    );

    spike_counter #(.CNT_W(4), .ISI_W(32)) dut4 (
        .clk         (clk),
        .reset_sim   (reset_sim),
        .enable      (enable),
        .window_len  (window_len),
        .spike       (spike),
        .count_ack   (count_ack),
        .count_out   (c4_count_out),
        .count_valid (c4_count_valid),
        .overrun     (c4_overrun),
        .total_count (c4_total_count),
        .last_isi    (c4_last_isi),
        .window_tick (c4_window_tick)
    );

    typedef struct {
        logic        spike;
        logic        ack;
        logic        valid;
        logic        ovr;
        logic [15:0] cnt;
        logic        tick;
        logic [15:0] total;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_sim  = 1'b1;
        enable     = 1'b0;
        spike      = 1'b0;
        count_ack  = 1'b0;
        window_len = 32'd0;
        repeat (3) tick();
        reset_sim = 1'b0;
        check("rst_count_out", count_out, 0);
        check("rst_count_valid", count_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_total", total_count, 0);
        check("rst_last_isi", last_isi, 0);
        check("rst_tick", window_tick, 0);
        $display("reset applied");
    endtask

    // One transition cycle IDLE->COUNT; the next cycle is window cycle 0.
    task automatic start(input logic [31:0] wl);
        window_len = wl;
        enable     = 1'b1;
        tick();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 16'd1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 16'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 16'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 16'd3};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 1'b1, 16'd3};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 16'd3};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 16'd3};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 16'd4};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 16'd4};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 16'd5};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 16'd5};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 16'd6};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'd2, 1'b1, 16'd6};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 16'd6};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 16'd6};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 16'd6};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b1, 16'd6};

        // Reset, then enabled with window_len=0 stays idle.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            spike = (i < 19) ? i[0] : 1'b0;
            tick();
            check($sformatf("idle_tick_%0d", i), window_tick, 0);
        end
        check("idle_total", total_count, 0);
        check("idle_valid", count_valid, 0);
        check("idle_count_out", count_out, 0);
        $display("idle window_len=0 done");

        // Basic 10-cycle window, pulses on cycles 2, 5, 9.
        do_reset();
        start(32'd10);
        for (int c = 0; c < 10; c++) begin
            if (c == 9) check("basic_valid_before_close", count_valid, 0);
            spike = (c == 2) || (c == 5) || (c == 9);
            tick();
        end
        spike = 1'b0;
        check("basic_count_out", count_out, 3);
        check("basic_count_valid", count_valid, 1);
        check("basic_tick", window_tick, 1);
        check("basic_total", total_count, 3);
        check("basic_last_isi", last_isi, 4);
        check("basic_c4_count_out", c4_count_out, 3);
        count_ack = 1'b1;
        tick();
        count_ack = 1'b0;
        check("basic_ack_valid", count_valid, 0);
        check("basic_ack_tick", window_tick, 0);
        check("basic_ack_count_out", count_out, 3);
        $display("basic window count_out=%0d", count_out);

        // Spike held high for 8 cycles counts once.
        do_reset();
        start(32'd10);
        for (int c = 0; c < 10; c++) begin
            spike = (c <= 7);
            tick();
        end
        spike = 1'b0;
        check("held_count_out", count_out, 1);
        check("held_total", total_count, 1);
        check("held_valid", count_valid, 1);
        check("held_tick", window_tick, 1);
        $display("held level count_out=%0d", count_out);

        // Overrun / ack-on-close table, window_len=4.
        do_reset();
        start(32'd4);
        for (int i = 0; i < 20; i++) begin
            spike     = vecs[i].spike;
            count_ack = vecs[i].ack;
            tick();
            check($sformatf("ovr_c%0d_valid", i), count_valid, vecs[i].valid);
            check($sformatf("ovr_c%0d_overrun", i), overrun, vecs[i].ovr);
            check($sformatf("ovr_c%0d_count", i), count_out, vecs[i].cnt);
            check($sformatf("ovr_c%0d_tick", i), window_tick, vecs[i].tick);
            check($sformatf("ovr_c%0d_total", i), total_count, vecs[i].total);
            $display("ovr cycle %0d valid=%0d overrun=%0d count=%0d", i, count_valid, overrun, count_out);
        end
        spike     = 1'b0;
        count_ack = 1'b0;

        // Saturation with 4-bit counts; edge every 2 cycles over 100 cycles.
        do_reset();
        start(32'd100);
        for (int c = 0; c < 100; c++) begin
            spike = (c % 2 == 0);
            tick();
        end
        spike = 1'b0;
        check("sat_c4_count_out", c4_count_out, 15);
        check("sat_c4_total", c4_total_count, 15);
        check("sat_c4_last_isi", c4_last_isi, 2);
        check("sat_wide_count_out", count_out, 50);
        check("sat_wide_total", total_count, 50);
        check("sat_wide_last_isi", last_isi, 2);
        check("sat_tick", window_tick, 1);
        $display("saturation c4=%0d wide=%0d", c4_count_out, count_out);

        // Shrink window_len mid-window, then drop enable mid-window.
        do_reset();
        start(32'd100);
        for (int c = 0; c < 25; c++) begin
            window_len = (c >= 20) ? 32'd5 : 32'd100;
            spike      = (c == 3) || (c == 10) || (c == 22);
            enable     = (c < 24);
            tick();
            if (c == 19) check("mid_valid_before_shrink", count_valid, 0);
            if (c == 20) begin
                check("mid_shrink_count_out", count_out, 2);
                check("mid_shrink_valid", count_valid, 1);
                check("mid_shrink_tick", window_tick, 1);
                check("mid_shrink_last_isi", last_isi, 7);
            end
            if (c == 23) check("mid_total_before_drop", total_count, 3);
        end
        spike = 1'b0;
        check("drop_count_out", count_out, 2);
        check("drop_total", total_count, 0);
        check("drop_valid", count_valid, 1);
        check("drop_tick", window_tick, 0);
        check("drop_last_isi", last_isi, 12);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("drop_idle_tick_%0d", i), window_tick, 0);
        end
        start(32'd5);
        for (int c = 0; c < 5; c++) tick();
        check("restart_count_out", count_out, 0);
        check("restart_valid", count_valid, 1);
        check("restart_overrun", overrun, 1);
        check("restart_tick", window_tick, 1);
        $display("mid-operation changes done count_out=%0d", count_out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
